// File: rtl/cpu_cache_pkg.sv
// Geometry, FSM state type and address-split helpers shared by the
// cache controller and its interface.
package cpu_cache_pkg;

  localparam int unsigned TAG_W    = 20;
  localparam int unsigned INDEX_W  = 8;
  localparam int unsigned OFFSET_W = 4;
  localparam int unsigned WORDS    = 4;

  typedef enum logic [2:0] {IDLE, COMPARE, WB, FILL, DONE} cc_state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
    return a[31:12];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [31:0] a);
    return a[11:4];
  endfunction

  function automatic logic [1:0] addr_word(input logic [31:0] a);
    return a[3:2];
  endfunction

  function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag,
                                            input logic [INDEX_W-1:0] index,
                                            input logic [1:0] word);
    return {tag, index, word, 2'b00};
  endfunction

endpackage

// File: rtl/cpu_cache_ctrl_if.sv
// CPU, cache-array and main-memory signals of the cache controller.
// The slave modport is the controller's view; master is the environment's.
interface cpu_cache_ctrl_if;
  import cpu_cache_pkg::*;

  logic                cpu_rd;
  logic                cpu_wr;
  logic [31:0]         cpu_addr;
  logic [31:0]         cpu_wdata;
  logic                cpu_ready;
  logic                cpu_done;
  logic [31:0]         cpu_rdata;

  logic                c_enable;
  logic                c_comp;
  logic                c_write;
  logic                c_valid_in;
  logic [INDEX_W-1:0]  c_index;
  logic [OFFSET_W-1:0] c_offset;
  logic [TAG_W-1:0]    c_tag_in;
  logic [31:0]         c_data_in;
  logic                c_hit;
  logic                c_valid;
  logic                c_dirty;
  logic [TAG_W-1:0]    c_tag_out;
  logic [31:0]         c_data_out;

  logic                mem_req;
  logic                mem_we;
  logic [31:0]         mem_addr;
  logic [31:0]         mem_wdata;
  logic                mem_ack;
  logic [31:0]         mem_rdata;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_ready, cpu_done, cpu_rdata,
    output c_enable, c_comp, c_write, c_valid_in, c_index, c_offset,
    output c_tag_in, c_data_in,
    input  c_hit, c_valid, c_dirty, c_tag_out, c_data_out,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_ready, cpu_done, cpu_rdata,
    input  c_enable, c_comp, c_write, c_valid_in, c_index, c_offset,
    input  c_tag_in, c_data_in,
    output c_hit, c_valid, c_dirty, c_tag_out, c_data_out,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/cpu_cache_ctrl.sv
// Write-back, write-allocate controller for a direct-mapped 256x4-word
// data cache: hit compare, dirty victim write-back, line refill.
module cpu_cache_ctrl
  import cpu_cache_pkg::*;
(
  input logic             clk,
  input logic             rst,
  cpu_cache_ctrl_if.slave bus
);

  cc_state_t          state, state_n;
  logic [1:0]         cnt;
  logic [TAG_W-1:0]   lat_tag;
  logic [TAG_W-1:0]   victim_tag;
  logic [INDEX_W-1:0] lat_index;
  logic [1:0]         lat_word;
  logic [31:0]        lat_wdata;
  logic               lat_wr;
  logic [31:0]        rdata;
  logic               accept;
  logic               hit;
  logic               last_ack;

  assign accept   = (state == IDLE) && (bus.cpu_rd || bus.cpu_wr);
  assign hit      = bus.c_hit && bus.c_valid;
  assign last_ack = bus.mem_ack && (cnt == 2'(WORDS - 1));

  assign bus.cpu_rdata = rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      lat_tag    <= '0;
      victim_tag <= '0;
      lat_index  <= '0;
      lat_word   <= '0;
      lat_wdata  <= '0;
      lat_wr     <= 1'b0;
      rdata      <= '0;
    end else begin
      if (accept) begin
        lat_tag   <= addr_tag(bus.cpu_addr);
        lat_index <= addr_index(bus.cpu_addr);
        lat_word  <= addr_word(bus.cpu_addr);
        lat_wdata <= bus.cpu_wdata;
        lat_wr    <= bus.cpu_wr;
      end
      case (state)
        COMPARE: begin
          if (hit) begin
            if (!lat_wr) rdata <= bus.c_data_out;
          end else begin
            cnt <= '0;
            if (bus.c_valid && bus.c_dirty) victim_tag <= bus.c_tag_out;
          end
        end
        WB, FILL: begin
          // Explicit clear on the last word so the counter never wraps on its own.
          if (bus.mem_ack) cnt <= last_ack ? 2'd0 : cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n        = state;
    bus.cpu_ready  = 1'b0;
    bus.cpu_done   = 1'b0;
    bus.c_enable   = 1'b0;
    bus.c_comp     = 1'b0;
    bus.c_write    = 1'b0;
    bus.c_valid_in = 1'b0;
    bus.c_index    = '0;
    bus.c_offset   = '0;
    bus.c_tag_in   = '0;
    bus.c_data_in  = '0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;

    case (state)
      IDLE: begin
        bus.cpu_ready = 1'b1;
        if (bus.cpu_rd || bus.cpu_wr) state_n = COMPARE;
      end
      COMPARE: begin
        bus.c_enable  = 1'b1;
        bus.c_comp    = 1'b1;
        bus.c_write   = lat_wr;
        bus.c_index   = lat_index;
        bus.c_offset  = {lat_word, 2'b00};
        bus.c_tag_in  = lat_tag;
        bus.c_data_in = lat_wdata;
        if (hit)                              state_n = DONE;
        else if (bus.c_valid && bus.c_dirty)  state_n = WB;
        else                                  state_n = FILL;
      end
      WB: begin
        bus.c_enable  = 1'b1;
        bus.c_index   = lat_index;
        bus.c_offset  = {cnt, 2'b00};
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = line_addr(victim_tag, lat_index, cnt);
        bus.mem_wdata = bus.c_data_out;
        if (last_ack) state_n = FILL;
      end
      FILL: begin
        bus.c_enable   = 1'b1;
        bus.c_write    = bus.mem_ack;
        bus.c_valid_in = 1'b1;
        bus.c_index    = lat_index;
        bus.c_offset   = {cnt, 2'b00};
        bus.c_tag_in   = lat_tag;
        bus.c_data_in  = bus.mem_rdata;
        bus.mem_req    = 1'b1;
        bus.mem_addr   = line_addr(lat_tag, lat_index, cnt);
        if (last_ack) state_n = COMPARE;
      end
      DONE: begin
        bus.cpu_done = 1'b1;
        bus.c_index  = lat_index;
        state_n      = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_cache_ctrl.sv
// Bench for cpu_cache_ctrl: emulates the cache array and a variable-latency
// memory, and checks CPU-visible results against a flat-memory reference.
module tb_cpu_cache_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_cache_ctrl_if bus();
  cpu_cache_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  // Cache array: synchronous writes, combinational lookup.
  logic [19:0] a_tag [256];
  bit          a_valid [256];
  bit          a_dirty [256];
  logic [31:0] a_data [256][4];

  assign bus.c_tag_out  = a_tag[bus.c_index];
  assign bus.c_valid    = a_valid[bus.c_index];
  assign bus.c_dirty    = a_dirty[bus.c_index];
  assign bus.c_hit      = (a_tag[bus.c_index] == bus.c_tag_in);
  assign bus.c_data_out = a_data[bus.c_index][bus.c_offset[3:2]];

  always @(posedge clk) begin
    if (bus.c_enable && bus.c_write) begin
      if (bus.c_comp) begin
        if (a_valid[bus.c_index] && a_tag[bus.c_index] == bus.c_tag_in) begin
          a_data[bus.c_index][bus.c_offset[3:2]] <= bus.c_data_in;
          a_dirty[bus.c_index] <= 1'b1;
        end
      end else begin
        a_data[bus.c_index][bus.c_offset[3:2]] <= bus.c_data_in;
        a_tag[bus.c_index]   <= bus.c_tag_in;
        a_valid[bus.c_index] <= bus.c_valid_in;
        a_dirty[bus.c_index] <= 1'b0;
      end
    end
  end

  // Main memory: each word takes lat cycles, ack in the last one.
  logic [31:0] mm [logic [31:0]];
  int          lat = 1;
  int          wcnt = 0;
  bit          pend = 0;
  logic [31:0] s_addr, s_wdata;
  logic        s_we;
  logic [31:0] wb_q[$], wbd_q[$], fill_q[$];

  function automatic logic [31:0] mm_rd(input logic [31:0] a);
    return mm.exists(a) ? mm[a] : init_word(a);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      pend = 0;
      wcnt = 0;
    end else begin
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        pend = 0;
        wcnt = 0;
      end
      if (bus.mem_req) begin
        if (pend) begin
          check("mem_addr_stable", bus.mem_addr, s_addr);
          check("mem_we_stable", {31'b0, bus.mem_we}, {31'b0, s_we});
          if (s_we) check("mem_wdata_stable", bus.mem_wdata, s_wdata);
        end else begin
          pend    = 1;
          s_addr  = bus.mem_addr;
          s_we    = bus.mem_we;
          s_wdata = bus.mem_wdata;
        end
        if (wcnt >= lat - 1) begin
          bus.mem_ack = 1'b1;
          if (bus.mem_we) begin
            mm[bus.mem_addr] = bus.mem_wdata;
            wb_q.push_back(bus.mem_addr);
            wbd_q.push_back(bus.mem_wdata);
          end else begin
            bus.mem_rdata = mm_rd(bus.mem_addr);
            fill_q.push_back(bus.mem_addr);
          end
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Reference: what the CPU should observe, plus which lines a direct-mapped
  // write-back cache would hold.
  logic [31:0] ref_mem [logic [31:0]];
  bit          rv [256];
  logic [19:0] rt [256];
  bit          rdirty [256];

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  task automatic do_op(input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input int l);
    logic [7:0]  idx;
    logic [19:0] tg, vt;
    logic [31:0] wa, ea;
    bit          hit, dirty;
    int          exp_cost, edges;
    idx   = addr[11:4];
    tg    = addr[31:12];
    wa    = {addr[31:2], 2'b00};
    hit   = rv[idx] && rt[idx] == tg;
    dirty = !hit && rv[idx] && rdirty[idx];
    vt    = rt[idx];
    exp_cost = hit ? 2 : (dirty ? 8 * l + 3 : 4 * l + 3);
    lat = l;
    wb_q.delete(); wbd_q.delete(); fill_q.delete();

    check("ready_before_op", {31'b0, bus.cpu_ready}, 32'd1);
    bus.cpu_rd = rd; bus.cpu_wr = wr; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    @(posedge clk); #1;
    bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0;
    for (edges = 1; edges <= 600; edges++) begin
      @(posedge clk); #1;
      if (bus.cpu_done === 1'b1) break;
    end
    check("op_cycles", edges + 1, exp_cost);
    check("wb_count", wb_q.size(), dirty ? 4 : 0);
    check("fill_count", fill_q.size(), hit ? 0 : 4);
    for (int k = 0; k < wb_q.size() && k < 4; k++) begin
      ea = {vt, idx, 2'(k), 2'b00};
      check("wb_addr", wb_q[k], ea);
      check("wb_data", wbd_q[k], ref_rd(ea));
    end
    for (int k = 0; k < fill_q.size() && k < 4; k++)
      check("fill_addr", fill_q[k], {tg, idx, 2'(k), 2'b00});
    if (!wr) check("load_data", bus.cpu_rdata, ref_rd(wa));

    if (!hit) begin rv[idx] = 1; rt[idx] = tg; rdirty[idx] = 0; end
    if (wr) begin ref_mem[wa] = wdata; rdirty[idx] = 1; end

    @(posedge clk); #1;
    check("done_one_cycle", {31'b0, bus.cpu_done}, 32'd0);
  endtask

  initial begin
    bit          found, seen;
    logic [19:0] tg;
    logic [7:0]  idx;
    int          op;

    rst = 1'b1;
    bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, bus.cpu_ready}, 32'd1);
    check("rst_done", {31'b0, bus.cpu_done}, 32'd0);
    check("rst_rdata", bus.cpu_rdata, 32'd0);
    check("rst_mem", {bus.mem_req, bus.mem_we, 30'b0}, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_c_ctl", {bus.c_enable, bus.c_comp, bus.c_write, bus.c_valid_in, bus.c_index, bus.c_offset}, 32'd0);
    check("rst_c_tag", {12'b0, bus.c_tag_in}, 32'd0);
    check("rst_c_data", bus.c_data_in, 32'd0);
    rst = 1'b0;

    do_op(1, 0, 32'h0000_1234, 32'h0, 1);
    check("line23_tag", {12'b0, a_tag[8'h23]}, 32'h1);
    check("line23_valid", {31'b0, a_valid[8'h23]}, 32'd1);
    do_op(1, 0, 32'h0000_1238, 32'h0, 1);
    do_op(0, 1, 32'h0000_1238, 32'hDEAD_BEEF, 1);
    check("line23_dirty", {31'b0, a_dirty[8'h23]}, 32'd1);
    do_op(1, 0, 32'h0000_2234, 32'h0, 2);
    check("wb_word2", wbd_q.size() > 2 ? wbd_q[2] : 32'h0, 32'hDEAD_BEEF);
    check("line23_newtag", {12'b0, a_tag[8'h23]}, 32'h2);
    do_op(1, 0, 32'h0000_3334, 32'h0, 5);

    // Reset in the middle of a refill, once the third word is on the bus.
    lat = 2;
    bus.cpu_rd = 1'b1; bus.cpu_addr = 32'h0000_5774;
    @(posedge clk); #1;
    bus.cpu_rd = 1'b0;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.mem_req && !bus.mem_we && bus.mem_addr[3:2] == 2'd2) begin
        found = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check("fill_cnt2_reached", {31'b0, found}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_midfill_req", {31'b0, bus.mem_req}, 32'd0);
    check("rst_midfill_ready", {31'b0, bus.cpu_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      seen |= bus.cpu_done;
    end
    check("rst_midfill_no_done", {31'b0, seen}, 32'd0);

    do_op(1, 1, 32'h0000_1238, 32'h0BAD_F00D, 1);
    do_op(1, 0, 32'h0000_1238, 32'h0, 1);

    for (int n = 0; n < 40; n++) begin
      tg = 20'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0:       idx = 8'h23;
        1:       idx = 8'h40;
        default: idx = 8'h41;
      endcase
      op = $urandom_range(0, 2);
      do_op(op != 1, op != 0, {tg, idx, 2'($urandom), 2'($urandom)}, $urandom, $urandom_range(1, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
